// File: rtl/sme_rng_dispenser.sv
// sme_rng_dispenser: consumer side of the SME random-number interface.
// Requests fresh guard-share bundles from the RNG source, buffers them in a
// small FIFO and hands them to the share ALU over valid/ready. Each bundle is
// delivered at most once.
// Optional feature: define SME_RNG_STUCK_CHECK_EN to drop (and flag) any
// captured bundle identical to the previous capture.
module sme_rng_dispenser #(
  parameter int XLEN    = 32,
  parameter int SMAX    = 3,
  parameter int DEPTH   = 4,
  parameter int RNG_LAT = 1,
  localparam int RMAX   = SMAX + SMAX * (SMAX - 1) / 2,
  localparam int BW     = RMAX * XLEN,
  localparam int LW     = $clog2(DEPTH + 1)
) (
  input  logic          g_clk,
  input  logic          g_reset,
  output logic          g_clk_req,
  output logic          rng_update,
  input  logic [BW-1:0] rng_in,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out_data,
  output logic [LW-1:0] level,
  output logic          stuck_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (RNG_LAT > 1) ? $clog2(RNG_LAT) : 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'((RNG_LAT > 1) ? (RNG_LAT - 2) : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt, next_cnt;

  logic [BW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [LW-1:0] level_q, level_after_pop;
  logic [BW-1:0] data_q;
  logic          capture_en, push, pop;

  // State register and latency counter; a synchronous reset aborts any request.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state logic: one request in flight, flush always returns to IDLE.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    if (flush) begin
      next_state = IDLE;
      next_cnt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (level_q < DEPTH_L) begin
            next_state = (RNG_LAT > 1) ? WAIT : CAPTURE;
            next_cnt   = '0;
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) next_state = CAPTURE;
          else                 next_cnt   = cnt + 1'b1;
        end
        CAPTURE: next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // FSM outputs: the update strobe only issues from IDLE with room and no flush.
  always_comb begin
    rng_update = (state == IDLE) && (level_q < DEPTH_L) && !flush;
    capture_en = (state == CAPTURE) && !flush;
    g_clk_req  = (state != IDLE) || rng_update;
  end

`ifdef SME_RNG_STUCK_CHECK_EN
  logic [BW-1:0] last_cap;
  logic          stuck_q;
  logic          stuck_hit;

  assign stuck_hit = (rng_in == last_cap);
  assign push      = capture_en && !stuck_hit;
  assign stuck_err = stuck_q;

  // Remember every non-aborted capture; a repeat sets the sticky stuck flag.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      last_cap <= '0;
      stuck_q  <= 1'b0;
    end else if (capture_en) begin
      last_cap <= rng_in;
      if (stuck_hit) stuck_q <= 1'b1;
    end
  end
`else
  assign push      = capture_en;
  assign stuck_err = 1'b0;
`endif

  assign out_valid       = (level_q != '0);
  assign pop             = out_valid && out_ready && !flush;
  assign rd_next         = pop ? (rd_ptr + 1'b1) : rd_ptr;
  assign level_after_pop = level_q - LW'(pop);
  assign level           = level_q;
  assign out_data        = data_q;

  // Bundle storage; stale entries are left in place and simply never exposed.
  always_ff @(posedge g_clk) begin
    if (push) mem[wr_ptr] <= rng_in;
  end

  // Pointers, level and the registered head copy; flush outranks push and pop.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      data_q  <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr  <= rd_next;
      level_q <= level_after_pop + LW'(push);
      if (level_after_pop != '0)
        data_q <= mem[rd_next];
      else if (push)
        data_q <= rng_in;
    end
  end

endmodule

// File: tb/tb_sme_rng_dispenser.sv
// tb_sme_rng_dispenser: scoreboard bench for sme_rng_dispenser.
// A queue-based reference model predicts requests, captures and pops; a
// negedge monitor compares the DUT against it every cycle.
module tb_sme_rng_dispenser;

  localparam int XLEN    = 32;
  localparam int SMAX    = 3;
  localparam int DEPTH   = 4;
  localparam int RNG_LAT = 1;
  localparam int RMAX    = SMAX + SMAX * (SMAX - 1) / 2;
  localparam int BW      = RMAX * XLEN;
  localparam int LW      = $clog2(DEPTH + 1);

  logic          g_clk;
  logic          g_reset;
  logic          g_clk_req;
  logic          rng_update;
  logic [BW-1:0] rng_in;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [LW-1:0] level;
  logic          stuck_err;

  int total = 0;
  int bad   = 0;
  int upd_count = 0;

  // Reference model state: expected FIFO contents and request progress.
  logic [BW-1:0] sb_q [$];
  int            pending = -1;
  logic [BW-1:0] last_cap = '0;
  bit            exp_stuck = 1'b0;
  bit            exp_upd = 1'b0;

  sme_rng_dispenser #(
    .XLEN(XLEN), .SMAX(SMAX), .DEPTH(DEPTH), .RNG_LAT(RNG_LAT)
  ) dut (
    .g_clk(g_clk), .g_reset(g_reset), .g_clk_req(g_clk_req),
    .rng_update(rng_update), .rng_in(rng_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .stuck_err(stuck_err)
  );

  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_bundle();
    logic [BW-1:0] r;
    for (int i = 0; i < RMAX; i++) r[i*XLEN +: XLEN] = $urandom;
    return r;
  endfunction

  // Drive one cycle of inputs just after the active edge, then wait for the next one.
  task automatic applyStimulus(input bit rst, input bit fl, input bit rdy, input logic [BW-1:0] data);
    g_reset   = rst;
    flush     = fl;
    out_ready = rdy;
    rng_in    = data;
    @(posedge g_clk);
    #1;
  endtask

  // Monitor: compare DUT against the model mid-cycle, then retire handshaken bundles.
  always @(negedge g_clk) begin
    exp_upd = (pending < 0) && (sb_q.size() < DEPTH) && !flush;
    if (!g_reset) begin
      if (rng_update) upd_count++;
      checkOutput("level", BW'(level), BW'(sb_q.size()));
      checkOutput("out_valid", BW'(out_valid), BW'(sb_q.size() != 0));
      checkOutput("rng_update", BW'(rng_update), BW'(exp_upd));
      checkOutput("g_clk_req", BW'(g_clk_req), BW'((pending >= 0) || exp_upd));
      checkOutput("stuck_err", BW'(stuck_err), BW'(exp_stuck));
      if (sb_q.size() != 0) begin
        checkOutput("head_data", out_data, sb_q[0]);
        if (out_ready && !flush) void'(sb_q.pop_front());
      end
    end
  end

  // Model: requests take RNG_LAT cycles, the capture lands in the expected queue.
  always @(posedge g_clk) begin
    if (g_reset) begin
      sb_q.delete();
      pending   = -1;
      last_cap  = '0;
      exp_stuck = 1'b0;
    end else if (flush) begin
      sb_q.delete();
      pending = -1;
    end else if (pending == 0) begin
      pending = -1;
`ifdef SME_RNG_STUCK_CHECK_EN
      if (rng_in == last_cap) exp_stuck = 1'b1;
      else                    sb_q.push_back(rng_in);
      last_cap = rng_in;
`else
      sb_q.push_back(rng_in);
`endif
    end else if (pending > 0) begin
      pending--;
    end else if (exp_upd) begin
      pending = RNG_LAT - 1;
    end
  end

  initial begin
    int base;
    logic [BW-1:0] prev;
    logic [BW-1:0] pat;
    pat = '0;
    for (int i = 0; i < BW / 8; i++) pat[i*8 +: 8] = 8'h5A;

    // Reset, then fill with the consumer stalled.
    applyStimulus(1, 0, 0, rand_bundle());
    applyStimulus(1, 0, 0, rand_bundle());
    base = upd_count;
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, rand_bundle());
    checkOutput("fill_updates", BW'(upd_count - base), BW'(4));
    checkOutput("fill_level", BW'(level), BW'(DEPTH));

    // Single pop from a full FIFO, then refill.
    base = upd_count;
    applyStimulus(0, 0, 1, rand_bundle());
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, rand_bundle());
    checkOutput("refill_updates", BW'(upd_count - base), BW'(1));
    checkOutput("refill_level", BW'(level), BW'(DEPTH));

    // Continuous consumer.
    for (int i = 0; i < 30; i++) applyStimulus(0, 0, 1, rand_bundle());

    // Flush with a partial FIFO and a capture in flight.
    applyStimulus(0, 1, 0, rand_bundle());
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, rand_bundle());
    applyStimulus(0, 1, 0, rand_bundle());
    checkOutput("flush_level", BW'(level), BW'(0));
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, rand_bundle());

    // Reset mid-request, then a constant RNG pattern.
    applyStimulus(1, 0, 0, rand_bundle());
    checkOutput("reset_level", BW'(level), BW'(0));
    checkOutput("reset_valid", BW'(out_valid), BW'(0));
    checkOutput("reset_data", out_data, '0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, pat);
`ifdef SME_RNG_STUCK_CHECK_EN
    checkOutput("stuck_level", BW'(level), BW'(1));
    checkOutput("stuck_flag", BW'(stuck_err), BW'(1));
`else
    checkOutput("stuck_level", BW'(level), BW'(DEPTH));
    checkOutput("stuck_flag", BW'(stuck_err), BW'(0));
`endif

    // Randomized traffic with occasional flush, reset and repeated bundles.
    prev = rand_bundle();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) >= 20) prev = rand_bundle();
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6,
                    1'($urandom_range(0, 1)), prev);
    end
    applyStimulus(0, 0, 1, rand_bundle());
    applyStimulus(0, 0, 1, rand_bundle());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
